// File: rtl/regfile_nr1w_pkg.sv
// Shared definitions for the decode-stage register file: default geometry
// and the address/data types used by the core datapath.
// Optional feature macro: REGFILE_BYPASS_EN (see rtl/regfile_nr1w.sv).
package regfile_pkg;

  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

endpackage

// File: rtl/regfile_nr1w_if.sv
// Write-back and operand-read bus of the register file.
// master = decode/WB side driving addresses and write data,
// slave  = register file returning the read operands.
interface regfile_nr1w_if
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD
);

  localparam int AW = $clog2(NUM_REGS);

  logic                           wr_en;
  logic [AW-1:0]                  wr_addr;
  logic [DATA_W-1:0]              wr_data;
  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/regfile_nr1w_mux_param_nto1.sv
// Generic W-bit N:1 multiplexer; one instance per register-file read port.
// N is a power of two, so every select value addresses a real input.
module mux_param_nto1 #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0][W-1:0]     din,
  input  logic [$clog2(N)-1:0]    sel,
  output logic [W-1:0]            dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile_nr1w.sv
// NUM_REGS x DATA_W register file with NUM_RD combinational read ports and
// one synchronous write port. Register ZERO_REG is hard-wired to zero
// (ZERO_REG = NUM_REGS disables it). Storage clears asynchronously on
// reset_n low.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a write in the
// current cycle is forwarded to any read port addressing the same register.
module regfile_nr1w
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic               clk,
  input  logic               reset_n,
  regfile_nr1w_if.slave      bus
);

  localparam int AW = $clog2(NUM_REGS);
  // One extra bit so ZERO_REG == NUM_REGS (disabled) never matches an address.
  localparam logic [AW:0] ZERO_IDX = (AW+1)'(ZERO_REG);

  // Flattened register contents feeding every read mux.
  logic [NUM_REGS-1:0][DATA_W-1:0] mux_in;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      if (gi == ZERO_REG) begin : g_zero
        // The zero register has no storage at all, so writes vanish.
        assign mux_in[gi] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q;
        logic              we;

        assign we = bus.wr_en && (bus.wr_addr == AW'(gi));

        // Register storage: async clear, load on a decoded write.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            q <= '0;
          end else if (we) begin
            q <= bus.wr_data;
          end
        end

        assign mux_in[gi] = q;
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DATA_W-1:0] mux_out;
      logic              rd_zero;

      mux_param_nto1 #(
        .N (NUM_REGS),
        .W (DATA_W)
      ) u_mux (
        .din  (mux_in),
        .sel  (bus.rd_addr[gi]),
        .dout (mux_out)
      );

      assign rd_zero = ({1'b0, bus.rd_addr[gi]} == ZERO_IDX);

`ifdef REGFILE_BYPASS_EN
      logic fwd;

      // Forward the in-flight WB value; the zero mask still takes priority,
      // which also suppresses forwarding of writes aimed at the zero register.
      assign fwd = reset_n && bus.wr_en && (bus.wr_addr == bus.rd_addr[gi]);
      assign bus.rd_data[gi] = rd_zero ? '0 : (fwd ? bus.wr_data : mux_out);
`else
      // Stored state only; a same-cycle write shows up on the next cycle.
      assign bus.rd_data[gi] = rd_zero ? '0 : mux_out;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_regfile_nr1w.sv
// Self-checking bench for regfile_nr1w: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against an
// array model of the register file.
module tb_regfile_nr1w;
  import regfile_pkg::*;

  localparam int NR = 32;
  localparam int NP = 2;
  localparam int ZR = 31;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  regfile_nr1w_if bus ();

  regfile_nr1w dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  reg_data_t model [NR] = '{default: '0};
  int        n_tests = 0;
  int        n_fail  = 0;
  bit        chk_on  = 1'b0;

  // Architectural state: cleared by reset, written on a clock edge unless
  // the target is the zero register.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      foreach (model[i]) model[i] <= '0;
    end else if (bus.wr_en && bus.wr_addr != reg_addr_t'(ZR)) begin
      model[bus.wr_addr] <= bus.wr_data;
    end
  end

  function automatic reg_data_t expect_rd(reg_addr_t a);
    if (a == reg_addr_t'(ZR)) return '0;
    if (!reset_n) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input reg_data_t got, input reg_data_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare every read port against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int p = 0; p < NP; p++) begin
        check($sformatf("port%0d_addr%0d", p, bus.rd_addr[p]),
              bus.rd_data[p], expect_rd(bus.rd_addr[p]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input reg_data_t d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = reg_addr_t'(a);
    bus.wr_data = d;
    cyc();
    bus.wr_en   = 1'b0;
  endtask

  function automatic reg_addr_t pick_addr();
    case ($urandom_range(0, 3))
      0:       return reg_addr_t'(ZR);
      1, 2:    return reg_addr_t'($urandom_range(0, 7));
      default: return reg_addr_t'($urandom_range(0, NR - 1));
    endcase
  endfunction

  initial begin
    reg_data_t exp0, exp1;

    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd1;
    chk_on = 1'b1;

    // Reset state
    #2;
    check("reset_p0", bus.rd_data[0], 64'h0);
    check("reset_p1", bus.rd_data[1], 64'h0);
    repeat (2) cyc();
    reset_n = 1'b1;
    $display("[TB] reset released");

    // Async reset mid-run after writing R5
    wr(5, 64'hDEAD);
    bus.rd_addr[0] = 5'd5;
    bus.rd_addr[1] = 5'd5;
    #1;
    check("r5_written", bus.rd_data[0], 64'hDEAD);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_p0", bus.rd_data[0], 64'h0);
    check("async_rst_p1", bus.rd_data[1], 64'h0);
    cyc();
    reset_n = 1'b1;
    #1;
    check("r5_after_rst", bus.rd_data[0], 64'h0);
    $display("[TB] async reset scenario");

    // Write/read two registers
    wr(1, 64'h0123456789ABCDEF);
    wr(30, 64'hFFFFFFFFFFFFFFFF);
    bus.rd_addr[0] = 5'd1;
    bus.rd_addr[1] = 5'd30;
    #1;
    check("r1", bus.rd_data[0], 64'h0123456789ABCDEF);
    check("r30", bus.rd_data[1], 64'hFFFFFFFFFFFFFFFF);
    bus.wr_en = 1'b0;
    bus.wr_addr = 5'd1;
    bus.wr_data = 64'h0;
    cyc();
    #1;
    check("r1_no_we", bus.rd_data[0], 64'h0123456789ABCDEF);
    $display("[TB] write/read scenario");

    // Zero register
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd31;
    bus.wr_data = 64'hAAAA;
    bus.rd_addr[0] = 5'd31;
    bus.rd_addr[1] = 5'd31;
    #1;
    check("zero_same_p0", bus.rd_data[0], 64'h0);
    check("zero_same_p1", bus.rd_data[1], 64'h0);
    cyc();
    bus.wr_en = 1'b0;
    #1;
    check("zero_after_p0", bus.rd_data[0], 64'h0);
    check("zero_after_p1", bus.rd_data[1], 64'h0);
    $display("[TB] zero register scenario");

    // Sweep
    for (int i = 0; i < 31; i++) wr(i, reg_data_t'(i * 'h0101));
    for (int k = 0; k < 32; k++) begin
      bus.rd_addr[0] = reg_addr_t'(k);
      bus.rd_addr[1] = reg_addr_t'(31 - k);
      #1;
      exp0 = (k == 31) ? 64'h0 : reg_data_t'(k * 'h0101);
      exp1 = (k == 0)  ? 64'h0 : reg_data_t'((31 - k) * 'h0101);
      check($sformatf("sweep_p0_%0d", k), bus.rd_data[0], exp0);
      check($sformatf("sweep_p1_%0d", 31 - k), bus.rd_data[1], exp1);
      cyc();
    end
    $display("[TB] sweep scenario");

    // Same-cycle write/read hazard on R7
    wr(7, 64'h11);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd7;
    bus.wr_data = 64'h22;
    bus.rd_addr[0] = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("hazard_same", bus.rd_data[0], 64'h22);
`else
    check("hazard_same", bus.rd_data[0], 64'h11);
`endif
    cyc();
    bus.wr_en = 1'b0;
    #1;
    check("hazard_next", bus.rd_data[0], 64'h22);
    $display("[TB] hazard scenario");

    // Reset coincident with a write
    wr(3, 64'h99);
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 64'h55;
    reset_n = 1'b0;
    cyc();
    bus.wr_en = 1'b0;
    reset_n = 1'b1;
    bus.rd_addr[0] = 5'd3;
    #1;
    check("rst_vs_wr", bus.rd_data[0], 64'h0);
    $display("[TB] reset-vs-write scenario");

    // Randomized traffic, checked by the per-cycle compare process
    for (int t = 0; t < 400; t++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      bus.wr_en = 1'($urandom_range(0, 1));
      bus.wr_addr = pick_addr();
      bus.wr_data = {$urandom, $urandom};
      for (int p = 0; p < NP; p++) begin
        bus.rd_addr[p] = ($urandom_range(0, 3) == 0) ? bus.wr_addr : pick_addr();
      end
      $display("[TB] txn %0d rst_n=%0d we=%0d wa=%0d wd=%h ra0=%0d ra1=%0d",
               t, reset_n, bus.wr_en, bus.wr_addr, bus.wr_data,
               bus.rd_addr[0], bus.rd_addr[1]);
      cyc();
    end

    reset_n = 1'b1;
    bus.wr_en = 1'b0;
    cyc();
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_nr1w.md
Name: regfile_nr1w

Overview:
- Parametrised register file: NUM_REGS x DATA_W storage, NUM_RD read ports, one synchronous write port.
- Generalised successor of the fixed 64-bit 32:1 read-mux datapath. Adds storage, write enable, a hard-wired zero register, per-port read selection and optional write-to-read bypass.
- Sits in the CPU decode stage. Feeds operand buses to the ALU. Written back from the WB stage.

Parameters:
- DATA_W, 64, bits per register
- NUM_REGS, 32, register count; must be a power of 2, >= 2
- NUM_RD, 2, number of independent read ports, 1..4
- ZERO_REG, 31, index hard-wired to zero; set to NUM_REGS to disable

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset; clears all registers
- wr_en  input  1  write strobe, sampled on rising clk
- wr_addr  input  $clog2(NUM_REGS)  write index
- wr_data  input  DATA_W  write data
- rd_addr  input  [NUM_RD-1:0][$clog2(NUM_REGS)-1:0]  per-port read index
- rd_data  output  [NUM_RD-1:0][DATA_W-1:0]  per-port read data

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n). All storage is cleared to 0 immediately on reset_n falling, independent of clk. Release of reset_n is synchronous to the design clock edge by system convention.
- During reset, every rd_data reads 0, because storage is 0.
- Write: on posedge clk with reset_n=1 and wr_en=1, mem[wr_addr] <= wr_data. The write is visible on reads the following cycle (1-cycle write-to-read latency).
- Write to ZERO_REG is silently discarded. mem[ZERO_REG] stays 0.
- wr_en=0: no state change, whatever wr_addr and wr_data hold.
- Read: combinational, zero latency. rd_data[p] = mem[rd_addr[p]]. rd_addr[p]==ZERO_REG always returns 0, regardless of any write or bypass.
- Ports are independent. Any number of ports may address the same register and each returns the identical value.
- Simultaneous write and read of the same address in one cycle (no bypass): the read returns the old value; the new value appears next cycle.
- reset_n asserted in the same cycle as a wr_en pulse: reset wins and the write is lost.
- Out-of-range addresses cannot occur because NUM_REGS is a power of 2.
- Each read port is a NUM_REGS:1 mux of DATA_W bits, implemented with the shared mux sub-module. There are no latches; storage is flip-flops only.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if wr_en=1, reset_n=1, wr_addr==rd_addr[p] and wr_addr!=ZERO_REG, then rd_data[p] = wr_data in the same cycle (combinational forward). This removes a WB->decode hazard.
- Undefined: no forwarding; rd_data always reflects the stored state, and a same-cycle read returns the old value.

Decomposition:
- Package regfile_pkg:
  - localparams DEF_DATA_W=64, DEF_NUM_REGS=32, DEF_ZERO_REG=31
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [63:0])
- Sub-module mux_param_nto1 (parameters N, W): generic W-bit N:1 mux, instantiated once per read port.
- Storage array, write decode, zero-register masking and bypass logic live in the top module.

Test Plan:
- Reset: hold reset_n=0 mid-run after writing 0xDEAD to R5 -> all rd_data=0 immediately (asynchronous, before next clk). After release, R5 reads 0.
- Write/read: write R1=0x0123456789ABCDEF, R30=0xFFFFFFFFFFFFFFFF. Next cycle rd_addr={1,30} -> rd_data={0x0123456789ABCDEF, 0xFFFFFFFFFFFFFFFF}. wr_en=0 with wr_addr=1, wr_data=0 -> R1 unchanged.
- Zero register: write R31=0xAAAA -> reading R31 on all ports returns 0 in that cycle and after. With bypass enabled, the forward to R31 is also suppressed.
- Sweep: write Ri=i*0x0101 for i=0..30, then sweep rd_addr[0]=0..31 and rd_addr[1]=31..0 -> each port returns the expected value; R31 returns 0.
- Same-cycle hazard: R7 holds 0x11; drive wr_en=1, wr_addr=7, wr_data=0x22, rd_addr[0]=7 -> rd_data[0]=0x11 without macro, 0x22 with REGFILE_BYPASS_EN. The following cycle reads 0x22 in both builds.
- Reset vs write: assert reset_n=0 coincident with wr_en=1, wr_addr=3, wr_data=0x55 -> after release, R3 reads 0.
